// File: rtl/sdram_ctrl_core.sv
// sdram_ctrl_core: command engine for a 4M x 16 SDRAM.
// Sequences power-up init, auto-refresh and single-word accesses.
module sdram_ctrl_core #(
  parameter int CAS_LATENCY      = 2,
  parameter int T_RCD            = 2,
  parameter int T_RP             = 2,
  parameter int T_RFC            = 7,
  parameter int T_WR             = 2,
  parameter int T_MRD            = 2,
  parameter int INIT_CYCLES      = 20000,
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_n,
  input  logic        re_n,
  input  logic [21:0] addr_in,
  input  logic [1:0]  be_in,
  output logic [11:0] addr_out,
  output logic [1:0]  ba_out,
  output logic [1:0]  dqm,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        sd_we_n,
  output logic        w_ready,
  output logic        waiting,
  output logic        valid,
  output logic        rd_incom,
  output logic [3:0]  cur_state,
  output logic [31:0] counter
);

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'd0,
    S_INIT_PRE  = 4'd1,
    S_INIT_REF1 = 4'd2,
    S_INIT_REF2 = 4'd3,
    S_INIT_MRS  = 4'd4,
    S_IDLE      = 4'd5,
    S_ACTIVATE  = 4'd6,
    S_READ      = 4'd7,
    S_READ_WAIT = 4'd8,
    S_WRITE     = 4'd9,
    S_PRECHARGE = 4'd10,
    S_REFRESH   = 4'd11
  } state_t;

  localparam logic [3:0] CMD_INH = 4'b1111;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // Single-location writes, sequential, burst length 1.
  localparam logic [11:0] MODE_WORD = {
    2'b00, 1'b1, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000
  };

  localparam logic [31:0] REF_LAST = 32'(REFRESH_INTERVAL - 1);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        cke_q, cke_d;
  logic        wr_q, wr_d;
  logic [21:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic        ref_en_q, ref_en_d;
  logic        ref_pend_q, ref_pend_d;
  logic [31:0] ref_cnt_q, ref_cnt_d;

  logic [31:0] dur;
  logic        last;
  logic        entry;
  logic [3:0]  cmd;
  logic [1:0]  bank;
  logic [11:0] row;
  logic [11:0] col;

  assign bank  = addr_q[21:20];
  assign row   = addr_q[19:8];
  assign col   = {4'b0000, addr_q[7:0]};
  assign entry = (cnt_q == 32'd0);
  assign last  = (cnt_q == dur - 32'd1);

  always_comb begin
    dur = 32'd1;
    unique case (state_q)
      S_INIT_WAIT: dur = 32'(INIT_CYCLES);
      S_INIT_PRE,
      S_PRECHARGE: dur = 32'(T_RP);
      S_INIT_REF1,
      S_INIT_REF2,
      S_REFRESH:   dur = 32'(T_RFC);
      S_INIT_MRS:  dur = 32'(T_MRD);
      S_ACTIVATE:  dur = 32'(T_RCD);
      S_READ_WAIT: dur = 32'(CAS_LATENCY);
      S_WRITE:     dur = 32'(T_WR);
      default:     dur = 32'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    be_d    = be_q;
    cke_d   = 1'b1;
    unique case (state_q)
      S_INIT_WAIT: if (last) state_d = S_INIT_PRE;
      S_INIT_PRE:  if (last) state_d = S_INIT_REF1;
      S_INIT_REF1: if (last) state_d = S_INIT_REF2;
      S_INIT_REF2: if (last) state_d = S_INIT_MRS;
      S_INIT_MRS:  if (last) state_d = S_IDLE;
      S_IDLE: begin
        // A pending refresh outranks any host request.
        if (ref_pend_q) begin
          state_d = S_REFRESH;
        end else if (!we_n || !re_n) begin
          state_d = S_ACTIVATE;
          wr_d    = !we_n;
          addr_d  = addr_in;
          be_d    = be_in;
        end
      end
      S_ACTIVATE: begin
        if (last) state_d = wr_q ? S_WRITE : S_READ;
      end
      S_READ:      if (last) state_d = S_READ_WAIT;
      S_READ_WAIT: if (last) state_d = S_PRECHARGE;
      S_WRITE:     if (last) state_d = S_PRECHARGE;
      S_PRECHARGE: if (last) state_d = S_IDLE;
      S_REFRESH:   if (last) state_d = S_IDLE;
      default:     state_d = S_INIT_WAIT;
    endcase
    cnt_d = (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
  end

  always_comb begin
    ref_en_d   = ref_en_q;
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    if (state_q == S_INIT_MRS && state_d == S_IDLE) begin
      ref_en_d = 1'b1;
    end
    if (state_q == S_IDLE && ref_pend_q) begin
      ref_pend_d = 1'b0;
    end
    if (ref_en_q) begin
      if (ref_cnt_q == REF_LAST) begin
        ref_cnt_d  = 32'd0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT_WAIT;
      cnt_q      <= '0;
      cke_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 2'b11;
      ref_en_q   <= 1'b0;
      ref_pend_q <= 1'b0;
      ref_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cke_q      <= cke_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      ref_en_q   <= ref_en_d;
      ref_pend_q <= ref_pend_d;
      ref_cnt_q  <= ref_cnt_d;
    end
  end

  always_comb begin
    cmd      = CMD_NOP;
    addr_out = '0;
    ba_out   = '0;
    dqm      = 2'b11;
    w_ready  = 1'b0;
    valid    = 1'b0;
    rd_incom = 1'b0;
    unique case (state_q)
      S_INIT_PRE: begin
        if (entry) begin
          cmd      = CMD_PRE;
          addr_out = 12'h400;
        end
      end
      S_INIT_REF1,
      S_INIT_REF2,
      S_REFRESH: begin
        if (entry) cmd = CMD_REF;
      end
      S_INIT_MRS: begin
        if (entry) begin
          cmd      = CMD_LMR;
          addr_out = MODE_WORD;
        end
      end
      S_ACTIVATE: begin
        if (entry) begin
          cmd      = CMD_ACT;
          ba_out   = bank;
          addr_out = row;
        end
      end
      S_READ: begin
        rd_incom = 1'b1;
        if (entry) begin
          cmd      = CMD_RD;
          ba_out   = bank;
          addr_out = col;
          dqm      = be_q;
        end
      end
      S_READ_WAIT: begin
        rd_incom = 1'b1;
        valid    = last;
      end
      S_WRITE: begin
        if (entry) begin
          cmd      = CMD_WR;
          ba_out   = bank;
          addr_out = col;
          dqm      = be_q;
          w_ready  = 1'b1;
        end
      end
      S_PRECHARGE: begin
        if (entry) begin
          cmd    = CMD_PRE;
          ba_out = bank;
        end
      end
      default: ;
    endcase
    if (!cke_q) cmd = CMD_INH;
  end

  assign {cs_n, ras_n, cas_n, sd_we_n} = cmd;
  assign cke       = cke_q;
  assign waiting   = !(state_q == S_IDLE && !ref_pend_q);
  assign cur_state = state_q;
  assign counter   = cnt_q;

endmodule

// File: tb/tb_sdram_ctrl_core.sv
// tb_sdram_ctrl_core: randomized bench for sdram_ctrl_core
// against a cycle-trace model built from the timing rules.
module tb_sdram_ctrl_core;

  localparam int CL   = 2;
  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int TWR  = 2;
  localparam int TMRD = 2;
  localparam int INIT = 10;
  localparam int RINT = 50;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  localparam logic [27:0] M_ALL  = 28'hFFFFFFF;
  localparam logic [27:0] M_NOP  = 28'hFF0003F;
  localparam logic [27:0] M_PRE  = 28'hFFD003F;
  localparam logic [27:0] M_IDLE = 28'hFF0003E;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we_n = 1'b1;
  logic        re_n = 1'b1;
  logic [21:0] addr_in = '0;
  logic [1:0]  be_in = '0;
  logic [11:0] addr_out;
  logic [1:0]  ba_out;
  logic [1:0]  dqm;
  logic        cke;
  logic        cs_n;
  logic        ras_n;
  logic        cas_n;
  logic        sd_we_n;
  logic        w_ready;
  logic        waiting;
  logic        valid;
  logic        rd_incom;
  logic [3:0]  cur_state;
  logic [31:0] counter;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;

  logic [27:0] exp_q[$];
  logic [27:0] msk_q[$];

  sdram_ctrl_core #(
    .CAS_LATENCY(CL), .T_RCD(TRCD), .T_RP(TRP),
    .T_RFC(TRFC), .T_WR(TWR), .T_MRD(TMRD),
    .INIT_CYCLES(INIT), .REFRESH_INTERVAL(RINT)
  ) dut (
    .clk(clk), .rst(rst), .we_n(we_n), .re_n(re_n),
    .addr_in(addr_in), .be_in(be_in),
    .addr_out(addr_out), .ba_out(ba_out), .dqm(dqm),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .sd_we_n(sd_we_n),
    .w_ready(w_ready), .waiting(waiting), .valid(valid),
    .rd_incom(rd_incom), .cur_state(cur_state),
    .counter(counter)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] cmd_now();
    return {cs_n, ras_n, cas_n, sd_we_n};
  endfunction

  function automatic logic [27:0] obs();
    return {cur_state, cs_n, ras_n, cas_n, sd_we_n, ba_out,
            addr_out, dqm, w_ready, valid, rd_incom, waiting};
  endfunction

  function automatic logic [27:0] pk(
    input logic [3:0] st, input logic [3:0] c,
    input logic [1:0] b, input logic [11:0] a,
    input logic [1:0] d, input logic wr, input logic v,
    input logic ri, input logic wt);
    return {st, c, b, a, d, wr, v, ri, wt};
  endfunction

  function automatic int init_dur(input int st);
    case (st)
      0: return INIT;
      1: return TRP;
      2: return TRFC;
      3: return TRFC;
      default: return TMRD;
    endcase
  endfunction

  // Expected per-cycle pin trace of one access, starting the
  // cycle after acceptance and ending on the return to IDLE.
  function automatic void build_trace(
    input bit is_wr, input logic [21:0] a, input logic [1:0] be);
    logic [1:0]  bk;
    logic [11:0] row;
    logic [11:0] col;
    bk  = a[21:20];
    row = a[19:8];
    col = {4'h0, a[7:0]};
    exp_q.delete();
    msk_q.delete();
    exp_q.push_back(pk(4'd6, C_ACT, bk, row, 2'b11, 0, 0, 0, 1));
    msk_q.push_back(M_ALL);
    for (int i = 1; i < TRCD; i++) begin
      exp_q.push_back(pk(4'd6, C_NOP, 0, 0, 2'b11, 0, 0, 0, 1));
      msk_q.push_back(M_NOP);
    end
    if (is_wr) begin
      exp_q.push_back(pk(4'd9, C_WR, bk, col, be, 1, 0, 0, 1));
      msk_q.push_back(M_ALL);
      for (int i = 1; i < TWR; i++) begin
        exp_q.push_back(pk(4'd9, C_NOP, 0, 0, 2'b11, 0, 0, 0, 1));
        msk_q.push_back(M_NOP);
      end
    end else begin
      exp_q.push_back(pk(4'd7, C_RD, bk, col, be, 0, 0, 1, 1));
      msk_q.push_back(M_ALL);
      for (int i = 1; i <= CL; i++) begin
        exp_q.push_back(pk(4'd8, C_NOP, 0, 0, 2'b11,
                           0, (i == CL), 1, 1));
        msk_q.push_back(M_NOP);
      end
    end
    exp_q.push_back(pk(4'd10, C_PRE, bk, 0, 2'b11, 0, 0, 0, 1));
    msk_q.push_back(M_PRE);
    for (int i = 1; i < TRP; i++) begin
      exp_q.push_back(pk(4'd10, C_NOP, 0, 0, 2'b11, 0, 0, 0, 1));
      msk_q.push_back(M_NOP);
    end
    exp_q.push_back(pk(4'd5, C_NOP, 0, 0, 2'b11, 0, 0, 0, 0));
    msk_q.push_back(M_IDLE);
  endfunction

  task automatic drive_req(
    input bit w, input bit r, input logic [21:0] a,
    input logic [1:0] be, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (!waiting) begin
        addr_in = a;
        be_in   = be;
        we_n    = !w;
        re_n    = !r;
        ok      = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    logic [60:0] got;
    logic [60:0] want;
    logic [11:0] mode;
    int  st;
    int  last_cnt;
    bit  done;
    bit  ok;
    rst  = 1'b1;
    we_n = 1'b1;
    re_n = 1'b1;
    #1;
    got  = {cur_state, counter, cke, cmd_now(), addr_out,
            ba_out, dqm, w_ready, valid, rd_incom, waiting};
    want = {4'd0, 32'd0, 1'b0, 4'b1111, 12'd0, 2'd0,
            2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_values got %h want %h", got, want);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mode = 12'h200 | 12'(CL << 4);
    st = 0;
    last_cnt = 0;
    done = 1'b0;
    for (int i = 0; i < INIT + 60 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (cke !== 1'b1) begin
          errors++;
          $display("FAIL cke_up got %b want 1", cke);
        end
      end
      if (cur_state == 4'(st)) begin
        last_cnt = int'(counter);
      end else if (cur_state == 4'(st + 1)) begin
        checks++;
        if (last_cnt != init_dur(st) - 1) begin
          errors++;
          $display("FAIL init_len st%0d got %0d want %0d",
                   st, last_cnt + 1, init_dur(st));
        end
        st++;
        checks++;
        if (counter !== 32'd0) begin
          errors++;
          $display("FAIL init_cnt st%0d got %0d want 0",
                   st, counter);
        end
        case (st)
          1: ok = (cmd_now() == C_PRE) && addr_out[10];
          2: ok = (cmd_now() == C_REF);
          3: ok = (cmd_now() == C_REF);
          4: ok = (cmd_now() == C_LMR) && (addr_out == mode)
                  && (ba_out == 2'd0);
          default: ok = (waiting == 1'b0);
        endcase
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL init_entry st%0d got cmd %b a %h w %b",
                   st, cmd_now(), addr_out, waiting);
        end
        if (st == 5) begin
          c0 = cyc;
          done = 1'b1;
        end
      end else begin
        errors++;
        $display("FAIL init_seq got %0d want %0d or %0d",
                 cur_state, st, st + 1);
        done = 1'b1;
      end
      if (st < 5) begin
        checks++;
        if (dqm !== 2'b11) begin
          errors++;
          $display("FAIL init_dqm got %b want 11", dqm);
        end
      end
    end
    checks++;
    if (st != 5) begin
      errors++;
      $display("FAIL init_done got st%0d want st5", st);
    end
  endtask

  task automatic test_refresh();
    int pend[$];
    int next_e;
    int served;
    int lat;
    logic [3:0] c;
    lat    = TRCD + 1 + CL + TRP + 1;
    next_e = c0 + RINT;
    served = 0;
    we_n = 1'b1;
    re_n = 1'b0;
    repeat (240) begin
      @(negedge clk);
      addr_in = 22'($urandom);
      be_in   = 2'($urandom);
      while (cyc >= next_e) begin
        pend.push_back(next_e);
        next_e += RINT;
      end
      c = cmd_now();
      if (pend.size() > 0 || cur_state == 4'd11) begin
        checks++;
        if (waiting !== 1'b1) begin
          errors++;
          $display("FAIL ref_waiting cyc %0d got %b want 1",
                   cyc, waiting);
        end
      end
      if (c == C_ACT && pend.size() > 0) begin
        checks++;
        if (cyc - 1 >= pend[0]) begin
          errors++;
          $display("FAIL ref_preempt cyc %0d got ACTIVE want REFRESH",
                   cyc);
        end
      end
      if (c == C_REF) begin
        checks++;
        if (pend.size() == 0) begin
          errors++;
          $display("FAIL ref_spurious cyc %0d got REFRESH want none",
                   cyc);
        end else begin
          if (cyc <= pend[0] || cyc - pend[0] > lat) begin
            errors++;
            $display("FAIL ref_latency got %0d want 1..%0d",
                     cyc - pend[0], lat);
          end
          void'(pend.pop_front());
          served++;
        end
      end
    end
    re_n = 1'b1;
    checks++;
    if (served < 4) begin
      errors++;
      $display("FAIL ref_count got %0d want 4", served);
    end
  endtask

  task automatic test_read();
    bit ok;
    logic [27:0] got;
    build_trace(1'b0, 22'h2ABCDE, 2'b00);
    drive_req(1'b0, 1'b1, 22'h2ABCDE, 2'b00, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_accept got busy want idle");
    end
    foreach (exp_q[k]) begin
      @(negedge clk);
      if (k == 0) begin we_n = 1'b1; re_n = 1'b1; end
      got = obs() & msk_q[k];
      checks++;
      if (got !== (exp_q[k] & msk_q[k])) begin
        errors++;
        $display("FAIL read k%0d got %h want %h",
                 k, got, exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_write();
    bit ok;
    logic [27:0] got;
    build_trace(1'b1, 22'h012345, 2'b10);
    drive_req(1'b1, 1'b0, 22'h012345, 2'b10, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_accept got busy want idle");
    end
    foreach (exp_q[k]) begin
      @(negedge clk);
      if (k == 0) begin we_n = 1'b1; re_n = 1'b1; end
      got = obs() & msk_q[k];
      checks++;
      if (got !== (exp_q[k] & msk_q[k])) begin
        errors++;
        $display("FAIL write k%0d got %h want %h",
                 k, got, exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    bit w;
    logic [21:0] a;
    logic [1:0]  be;
    logic [27:0] got;
    for (int n = 0; n < 16; n++) begin
      w  = 1'($urandom_range(0, 1));
      a  = 22'($urandom);
      be = 2'($urandom);
      build_trace(w, a, be);
      drive_req(w, !w, a, be, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rand_accept n%0d got busy want idle", n);
      end
      foreach (exp_q[k]) begin
        @(negedge clk);
        if (k == 0) begin we_n = 1'b1; re_n = 1'b1; end
        got = obs() & msk_q[k];
        checks++;
        if (got !== (exp_q[k] & msk_q[k])) begin
          errors++;
          $display("FAIL rand n%0d k%0d got %h want %h",
                   n, k, got, exp_q[k] & msk_q[k]);
        end
      end
    end
  endtask

  task automatic test_both_low();
    bit ok;
    logic [27:0] got;
    build_trace(1'b1, 22'h1F0F33, 2'b01);
    drive_req(1'b1, 1'b1, 22'h1F0F33, 2'b01, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL both_accept got busy want idle");
    end
    foreach (exp_q[k]) begin
      @(negedge clk);
      if (k == 0) begin we_n = 1'b1; re_n = 1'b1; end
      got = obs() & msk_q[k];
      checks++;
      if (got !== (exp_q[k] & msk_q[k])) begin
        errors++;
        $display("FAIL both_low k%0d got %h want %h",
                 k, got, exp_q[k] & msk_q[k]);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    bit hit;
    hit = 1'b0;
    drive_req(1'b0, 1'b1, 22'h3C0155, 2'b00, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_accept got busy want idle");
    end
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      we_n = 1'b1;
      re_n = 1'b1;
      if (cur_state == 4'd8) hit = 1'b1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reach got state %0d want 8", cur_state);
    end
    test_reset();
  endtask

  initial begin
    #3;
    test_reset();
    test_refresh();
    test_read();
    test_write();
    test_random();
    test_both_low();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
